// File: rtl/sequential_divider_pkg.sv
// Shared types and constants for the signed sequential divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned W_DEFAULT = 32;

    // Step counter must hold 0..W.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Largest positive W-bit signed value, zero-extended to 64 bits (W <= 64).
    function automatic logic [63:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative W-bit signed value as a W-bit pattern, zero-extended (W <= 64).
    function automatic logic [63:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface sequential_divider_if
    import seq_div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) ();

    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, busy, div_by_zero, overflow
    );

endinterface

// File: rtl/sequential_divider_twos_abs.sv
// Conditional two's-complement negate: magnitude extraction and sign application.
module twos_abs #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic         neg,
    output logic [N-1:0] y
);

    // Negate when requested; the most negative value maps onto itself as unsigned.
    assign y = neg ? (~a + N'(1)) : a;

endmodule

// File: rtl/sequential_divider.sv
// Signed restoring divider, one quotient bit per clock: 2W-bit dividend / W-bit divisor.
// Optional SEQ_DIVIDER_SATURATE_EN: error results saturate the quotient instead of zeroing it.
module sequential_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    sequential_divider_if.slave   bus
);

    localparam int unsigned W2 = 2 * W;
    localparam int unsigned CW = cnt_width(W);

`ifdef SEQ_DIVIDER_SATURATE_EN
    localparam logic [W-1:0] SAT_POS = W'(sat_pos(W));
    localparam logic [W-1:0] SAT_NEG = W'(sat_neg(W));
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            pend_dbz_q, pend_dbz_d;
    logic            pend_ovf_q, pend_ovf_d;
    logic [W-1:0]    dmag_q, dmag_d;
    logic [W-1:0]    part_q, part_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [W2-1:0]   dd_abs;
    logic [W-1:0]    dv_abs;
    logic [W-1:0]    q_signed;
    logic [W-1:0]    r_signed;
    logic [W:0]      trial;
    logic            trial_ge;
    logic [W-1:0]    trial_diff;
    logic            range_ovf;
    logic            fin_ovf;
    logic [W-1:0]    err_quot;

    twos_abs #(.N(W2)) u_abs_dividend (.a(bus.dividend), .neg(bus.dividend[W2-1]), .y(dd_abs));
    twos_abs #(.N(W))  u_abs_divisor  (.a(bus.divisor),  .neg(bus.divisor[W-1]),   .y(dv_abs));
    twos_abs #(.N(W))  u_sign_quot    (.a(shreg_q),      .neg(qneg_q),            .y(q_signed));
    twos_abs #(.N(W))  u_sign_rem     (.a(part_q),       .neg(rneg_q),            .y(r_signed));

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial      = {part_q, shreg_q[W-1]};
    assign trial_ge   = (trial >= {1'b0, dmag_q});
    assign trial_diff = W'(trial - {1'b0, dmag_q});

    // Quotient magnitude must fit the signed W-bit range for its final sign.
    assign range_ovf = qneg_q ? (shreg_q[W-1] & (|shreg_q[W-2:0])) : shreg_q[W-1];
    assign fin_ovf   = !pend_dbz_q && (pend_ovf_q || range_ovf);

    // Quotient reported on div_by_zero / overflow.
`ifdef SEQ_DIVIDER_SATURATE_EN
    assign err_quot = (pend_dbz_q ? rneg_q : qneg_q) ? SAT_NEG : SAT_POS;
`else
    assign err_quot = '0;
`endif

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        pend_dbz_d = pend_dbz_q;
        pend_ovf_d = pend_ovf_q;
        dmag_d     = dmag_q;
        part_d     = part_q;
        shreg_d    = shreg_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        done_d     = done_q;
        busy_d     = busy_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    qneg_d     = bus.dividend[W2-1] ^ bus.divisor[W-1];
                    rneg_d     = bus.dividend[W2-1];
                    dmag_d     = dv_abs;
                    part_d     = dd_abs[W2-1:W];
                    shreg_d    = dd_abs[W-1:0];
                    cnt_d      = '0;
                    pend_dbz_d = 1'b0;
                    pend_ovf_d = 1'b0;
                    done_d     = 1'b0;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (bus.divisor == '0) begin
                        pend_dbz_d = 1'b1;
                        state_d    = FINISH;
                    end else if (dd_abs[W2-1:W] >= dv_abs) begin
                        pend_ovf_d = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                part_d  = trial_ge ? trial_diff : trial[W-1:0];
                shreg_d = {shreg_q[W-2:0], trial_ge};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                dbz_d  = pend_dbz_q;
                ovf_d  = fin_ovf;
                if (pend_dbz_q || fin_ovf) begin
                    quot_d = err_quot;
                    rem_d  = '0;
                end else begin
                    quot_d = q_signed;
                    rem_d  = r_signed;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            pend_dbz_q <= 1'b0;
            pend_ovf_q <= 1'b0;
            dmag_q     <= '0;
            part_q     <= '0;
            shreg_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            pend_dbz_q <= pend_dbz_d;
            pend_ovf_q <= pend_ovf_d;
            dmag_q     <= dmag_d;
            part_q     <= part_d;
            shreg_q    <= shreg_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at W=8 against an arithmetic reference model.
module tb_sequential_divider;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    sequential_divider_if #(.W(W)) bus ();

    sequential_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic signed [15:0] dd_tab [11] = '{16'sd100, -16'sd100, 16'sd100, -16'sd100, 16'sd55,
                                        16'sd4096, 16'sd1024, -16'sd1024, -16'sd32768,
                                        -16'sd55, 16'sd32767};
    logic signed [7:0]  dv_tab [11] = '{8'sd7, 8'sd7, -8'sd7, -8'sd7, 8'sd0,
                                        8'sd8, 8'sd8, 8'sd8, -8'sd1,
                                        8'sd0, 8'sd127};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one division, optionally poking start mid-run, and check it against the model.
    task automatic do_op(input logic signed [15:0] dd, input logic signed [7:0] dv,
                         input bit poke, input string tag);
        longint a, b, qt, rt, qa, e_q, e_r;
        bit     e_dbz, e_ovf, early;
        int     lat, n;
        bit     sat;
`ifdef SEQ_DIVIDER_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        a = longint'(dd);
        b = longint'(dv);
        if (b == 0) begin
            e_dbz = 1'b1;
            e_ovf = 1'b0;
            early = 1'b1;
            e_q   = sat ? ((a < 0) ? -128 : 127) : 0;
            e_r   = 0;
        end else begin
            qt    = a / b;
            rt    = a % b;
            qa    = ((a < 0) ? -a : a) / ((b < 0) ? -b : b);
            early = (qa >= 256);
            e_dbz = 1'b0;
            e_ovf = (qt > 127) || (qt < -128);
            if (e_ovf) begin
                e_q = sat ? ((qt < 0) ? -128 : 127) : 0;
                e_r = 0;
            end else begin
                e_q = qt;
                e_r = rt;
            end
        end
        lat = early ? 2 : (W + 2);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(posedge clk); #1;
        n = 1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        chk({tag, ".busy_after_start"}, 64'(bus.busy), 1);
        chk({tag, ".done_cleared"}, 64'(bus.done), 0);
        chk({tag, ".flags_cleared"}, 64'({bus.div_by_zero, bus.overflow}), 0);

        while (!bus.done && n < 40) begin
            if (poke && n == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 16'sd999;
                bus.divisor  = 8'sd3;
            end else begin
                bus.start    = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;

        chk({tag, ".done"}, 64'(bus.done), 1);
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".quotient"}, 64'($signed(bus.quotient)), e_q);
        chk({tag, ".remainder"}, 64'($signed(bus.remainder)), e_r);
        chk({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(e_dbz));
        chk({tag, ".overflow"}, 64'(bus.overflow), 64'(e_ovf));
        chk({tag, ".busy_at_done"}, 64'(bus.busy), 0);
    endtask

    initial begin
        logic signed [15:0] rdd;
        logic signed [7:0]  rdv;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", 64'({bus.quotient, bus.remainder, bus.done, bus.busy,
                                  bus.div_by_zero, bus.overflow}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases; consecutive calls also exercise start on the done-rise cycle.
        for (int i = 0; i < 11; i++) begin
            do_op(dd_tab[i], dv_tab[i], 1'b0, $sformatf("dir%0d", i));
        end

        // A second start while busy must not disturb the running division.
        do_op(16'sd100, 8'sd7, 1'b1, "poke");

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'sd100;
        bus.divisor  = 8'sd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.outputs", 64'({bus.quotient, bus.remainder, bus.done, bus.busy,
                                   bus.div_by_zero, bus.overflow}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("midrst.no_done", 64'({bus.done, bus.busy}), 0);
        do_op(16'sd100, 8'sd7, 1'b0, "after_rst");

        // Randomized operands with reduced dividend magnitude to reach full runs often.
        for (int i = 0; i < 60; i++) begin
            rdd = 16'($urandom);
            rdd = rdd >>> $urandom_range(0, 9);
            rdv = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rdv = '0;
            end
            do_op(rdd, rdv, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
